// File: rtl/iigs_mem_pkg.sv
// Shared types for the fast-RAM / DMA scheduler in front of the SDRAM channel.
// Holds the scheduler state encoding, requester ids and the bank prefixes
// that place CPU and DMA traffic in separate SDRAM regions.
package iigs_mem_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_RISE,
        WAIT_FALL,
        DONE
    } sched_state_t;

    typedef enum logic {
        REQ_CPU = 1'b0,
        REQ_DMA = 1'b1
    } req_id_t;

    localparam logic [1:0] CPU_BANK_DEFAULT = 2'b00;
    localparam logic [1:0] DMA_BANK_DEFAULT = 2'b01;

endpackage

// File: rtl/fastram_sched_grant.sv
// Purpose: picks which requester the scheduler serves next (FASTRAM_SCHED_RR_EN selects round-robin).
// Latency: purely combinational; the caller registers the result on grant.
// Backpressure: none here; the caller only samples the grant while idle and the channel is free.
module fastram_sched_grant
    import iigs_mem_pkg::*;
(
    input  logic    cpu_req,
    input  logic    dma_req,
    input  req_id_t last_grant,
    output logic    grant_vld,
    output req_id_t grant_id
);

`ifdef FASTRAM_SCHED_RR_EN
    // Tie goes to whoever was not served last; a lone request always wins.
    always_comb begin
        grant_vld = cpu_req | dma_req;
        grant_id  = REQ_CPU;
        if (cpu_req && dma_req) begin
            grant_id = (last_grant == REQ_CPU) ? REQ_DMA : REQ_CPU;
        end else if (dma_req) begin
            grant_id = REQ_DMA;
        end
    end
`else
    // Fixed priority: history is irrelevant, CPU wins every tie.
    logic unused_last_grant;
    assign unused_last_grant = ^last_grant;

    // CPU first, DMA only when the CPU is not asking.
    always_comb begin
        grant_vld = cpu_req | dma_req;
        grant_id  = (cpu_req) ? REQ_CPU : (dma_req ? REQ_DMA : REQ_CPU);
    end
`endif

endmodule

// File: rtl/fastram_sdram_sched.sv
// Purpose: shares the byte-wide SDRAM channel between the CPU fast-RAM port and the DMA port (FASTRAM_SCHED_RR_EN: round-robin ties).
// Latency: grant, 1-cycle strobe, wait for busy to rise and fall (or 15-cycle rise timeout), then a 1-cycle ack.
// Backpressure: requesters hold req until ack; cpu_wait stalls the core; no grant while mem_busy is high.
module fastram_sdram_sched
    import iigs_mem_pkg::*;
#(
    parameter int         ADDR_W       = 23,
    parameter int         MEM_ADDR_W   = 25,
    parameter logic [1:0] CPU_BANK     = CPU_BANK_DEFAULT,
    parameter logic [1:0] DMA_BANK     = DMA_BANK_DEFAULT,
    parameter int         BUSY_TIMEOUT = 15
) (
    input  logic                  clk_sys,
    input  logic                  reset,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_W-1:0]     cpu_addr,
    input  logic [7:0]            cpu_din,
    output logic [7:0]            cpu_dout,
    output logic                  cpu_ack,
    output logic                  cpu_wait,
    input  logic                  dma_req,
    input  logic                  dma_we,
    input  logic [ADDR_W-1:0]     dma_addr,
    input  logic [7:0]            dma_din,
    output logic [7:0]            dma_dout,
    output logic                  dma_ack,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    output logic                  mem_wr,
    output logic                  mem_rd,
    output logic [7:0]            mem_din,
    input  logic [7:0]            mem_dout,
    input  logic                  mem_busy
);

    // Last WAIT_RISE count before giving up on busy ever rising.
    localparam logic [3:0] TIMEOUT_LAST = 4'(BUSY_TIMEOUT - 1);

    sched_state_t state;
    req_id_t      gnt;
    req_id_t      last_grant;
    req_id_t      grant_id;
    logic         grant_vld;
    logic         acc_we;
    logic [3:0]   rise_cnt;

    fastram_sched_grant u_grant (
        .cpu_req    (cpu_req),
        .dma_req    (dma_req),
        .last_grant (last_grant),
        .grant_vld  (grant_vld),
        .grant_id   (grant_id)
    );

    // Stall the core while its request is open; drops in the ack cycle or with req.
    assign cpu_wait = cpu_req & ~((gnt == REQ_CPU) && (state == DONE));

    // Access sequencer: strobes, acks and read data are all registered here.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state      <= IDLE;
            gnt        <= REQ_CPU;
            last_grant <= REQ_DMA;
            acc_we     <= 1'b0;
            rise_cnt   <= 4'd0;
            mem_addr   <= '0;
            mem_din    <= 8'd0;
            mem_wr     <= 1'b0;
            mem_rd     <= 1'b0;
            cpu_dout   <= 8'd0;
            dma_dout   <= 8'd0;
            cpu_ack    <= 1'b0;
            dma_ack    <= 1'b0;
        end else begin
            mem_wr  <= 1'b0;
            mem_rd  <= 1'b0;
            cpu_ack <= 1'b0;
            dma_ack <= 1'b0;
            case (state)
                IDLE: begin
                    // A channel still finishing earlier work must not see a new strobe.
                    if (grant_vld && !mem_busy) begin
                        gnt        <= grant_id;
                        last_grant <= grant_id;
                        state      <= ISSUE;
                        if (grant_id == REQ_CPU) begin
                            acc_we   <= cpu_we;
                            mem_addr <= MEM_ADDR_W'({CPU_BANK, cpu_addr});
                            mem_din  <= cpu_din;
                            mem_wr   <= cpu_we;
                            mem_rd   <= ~cpu_we;
                        end else begin
                            acc_we   <= dma_we;
                            mem_addr <= MEM_ADDR_W'({DMA_BANK, dma_addr});
                            mem_din  <= dma_din;
                            mem_wr   <= dma_we;
                            mem_rd   <= ~dma_we;
                        end
                    end
                end
                ISSUE: begin
                    rise_cnt <= 4'd0;
                    state    <= WAIT_RISE;
                end
                WAIT_RISE: begin
                    if (mem_busy) begin
                        state <= WAIT_FALL;
                    end else if (rise_cnt == TIMEOUT_LAST) begin
                        // Channel never acknowledged; complete without read data so nobody hangs.
                        state   <= DONE;
                        cpu_ack <= (gnt == REQ_CPU);
                        dma_ack <= (gnt == REQ_DMA);
                    end else begin
                        rise_cnt <= rise_cnt + 4'd1;
                    end
                end
                WAIT_FALL: begin
                    if (!mem_busy) begin
                        state   <= DONE;
                        cpu_ack <= (gnt == REQ_CPU);
                        dma_ack <= (gnt == REQ_DMA);
                        if (!acc_we) begin
                            if (gnt == REQ_CPU) begin
                                cpu_dout <= mem_dout;
                            end else begin
                                dma_dout <= mem_dout;
                            end
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fastram_sdram_sched.sv
// Bench for fastram_sdram_sched: randomized and directed traffic from both ports,
// a reference model that predicts service order, strobes, acks and read data,
// and a monitor that checks the DUT against the predicted queues.
module tb_fastram_sdram_sched;

`ifdef FASTRAM_SCHED_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    localparam int BUSY_TO = 15;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, dma_req, dma_we;
    logic [22:0] cpu_addr, dma_addr;
    logic [7:0]  cpu_din, dma_din, cpu_dout, dma_dout;
    logic        cpu_ack, cpu_wait, dma_ack;
    logic [24:0] mem_addr;
    logic        mem_wr, mem_rd, mem_busy;
    logic [7:0]  mem_din, mem_dout;
    logic        resp_busy, hold_busy;

    assign mem_busy = resp_busy | hold_busy;

    always #5 clk_sys = ~clk_sys;

    fastram_sdram_sched dut (
        .clk_sys  (clk_sys),  .reset    (reset),
        .cpu_req  (cpu_req),  .cpu_we   (cpu_we),   .cpu_addr (cpu_addr),
        .cpu_din  (cpu_din),  .cpu_dout (cpu_dout), .cpu_ack  (cpu_ack),
        .cpu_wait (cpu_wait),
        .dma_req  (dma_req),  .dma_we   (dma_we),   .dma_addr (dma_addr),
        .dma_din  (dma_din),  .dma_dout (dma_dout), .dma_ack  (dma_ack),
        .mem_addr (mem_addr), .mem_wr   (mem_wr),   .mem_rd   (mem_rd),
        .mem_din  (mem_din),  .mem_dout (mem_dout), .mem_busy (mem_busy)
    );

    typedef struct { logic we; logic [22:0] addr; logic [7:0] din; } acc_t;
    typedef struct { logic we; logic [24:0] addr; logic [7:0] din; } strobe_t;
    typedef struct {
        bit dma; logic we; logic [24:0] addr; logic [7:0] din;
        logic [7:0] rdata; bit chk_data; int exp_lat;
    } ack_t;

    strobe_t    sq[$];
    ack_t       aq[$];
    acc_t       cpu_list[$];
    acc_t       dma_list[$];
    logic [7:0] ref_mem [logic [24:0]];
    logic [7:0] sd_mem  [logic [24:0]];
    logic [7:0] exp_dout [2];
    bit         model_last;     // 1 = DMA served last
    int         busy_len;
    int         cyc = 0;
    int         scen_start = 0;
    int         strobe_cnt = 0;
    int         errors = 0;
    int         checks = 0;

    always @(posedge clk_sys) cyc <= cyc + 1;

    function automatic logic [7:0] dflt(input logic [24:0] a);
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5A;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event seen, expected none (cycle %0d)", name, cyc);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_mem_rd"},   32'(mem_rd),   32'd0);
        chk({tag, "_mem_wr"},   32'(mem_wr),   32'd0);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        chk({tag, "_mem_din"},  32'(mem_din),  32'd0);
        chk({tag, "_cpu_dout"}, 32'(cpu_dout), 32'd0);
        chk({tag, "_dma_dout"}, 32'(dma_dout), 32'd0);
        chk({tag, "_cpu_ack"},  32'(cpu_ack),  32'd0);
        chk({tag, "_dma_ack"},  32'(dma_ack),  32'd0);
        chk({tag, "_cpu_wait"}, 32'(cpu_wait), 32'd0);
    endtask

    // Reference model: record what one access should look like on the channel and at ack.
    task automatic push_exp(input bit d, input acc_t a, input bit chk_data, input int lat);
        strobe_t     s;
        ack_t        k;
        logic [24:0] ma;
        ma     = {(d ? 2'b01 : 2'b00), a.addr};
        s.we   = a.we;  s.addr = ma;  s.din = a.din;
        sq.push_back(s);
        k.dma  = d;     k.we = a.we;  k.addr = ma;  k.din = a.din;
        k.chk_data = chk_data;  k.exp_lat = lat;
        if (a.we) begin
            ref_mem[ma] = a.din;
            k.rdata     = 8'd0;
        end else begin
            k.rdata = ref_mem.exists(ma) ? ref_mem[ma] : dflt(ma);
        end
        aq.push_back(k);
        model_last = d;
    endtask

    // SDRAM stand-in: busy rises the cycle after a strobe, lasts busy_len cycles, read data at the fall.
    initial begin
        logic [24:0] ra;
        logic        rw;
        resp_busy = 1'b0;
        mem_dout  = 8'd0;
        forever begin
            @(negedge clk_sys);
            if ((mem_rd || mem_wr) && !reset) begin
                ra = mem_addr;
                rw = mem_wr;
                if (rw) sd_mem[ra] = mem_din;
                if (busy_len > 0) begin
                    @(posedge clk_sys);
                    #1 resp_busy = 1'b1;
                    repeat (busy_len) @(posedge clk_sys);
                    #1 resp_busy = 1'b0;
                    mem_dout = rw ? 8'($urandom) : (sd_mem.exists(ra) ? sd_mem[ra] : dflt(ra));
                end
            end
        end
    end

    // Monitor: pop and compare whenever the DUT strobes or acks.
    strobe_t ms;
    ack_t    ma_k;
    always @(negedge clk_sys) begin
        if (!reset) begin
            if (mem_rd || mem_wr) begin
                strobe_cnt++;
                if (sq.size() == 0) begin
                    fail("unexpected_strobe");
                end else begin
                    ms = sq.pop_front();
                    chk("strobe_kind", 32'({mem_wr, mem_rd}), ms.we ? 32'd2 : 32'd1);
                    chk("strobe_addr", 32'(mem_addr), 32'(ms.addr));
                    if (ms.we) chk("strobe_din", 32'(mem_din), 32'(ms.din));
                end
            end
            if (cpu_ack && dma_ack) fail("both_acks");
            if (cpu_ack || dma_ack) begin
                if (aq.size() == 0) begin
                    fail("unexpected_ack");
                end else begin
                    ma_k = aq.pop_front();
                    chk("ack_port", 32'(dma_ack), 32'(ma_k.dma));
                    chk("ack_addr_held", 32'(mem_addr), 32'(ma_k.addr));
                    if (ma_k.we) chk("ack_din_held", 32'(mem_din), 32'(ma_k.din));
                    if (!ma_k.we && ma_k.chk_data) exp_dout[ma_k.dma] = ma_k.rdata;
                    chk(ma_k.dma ? "dma_dout" : "cpu_dout",
                        32'(ma_k.dma ? dma_dout : cpu_dout), 32'(exp_dout[ma_k.dma]));
                    if (ma_k.exp_lat >= 0) chk("latency", 32'(cyc - scen_start), 32'(ma_k.exp_lat));
                end
            end
            chk("cpu_wait", 32'(cpu_wait), 32'(cpu_req & ~cpu_ack));
        end
    end

    task automatic cpu_drive();
        int n;
        foreach (cpu_list[i]) begin
            cpu_we = cpu_list[i].we;  cpu_addr = cpu_list[i].addr;
            cpu_din = cpu_list[i].din; cpu_req = 1'b1;
            n = 0;
            do begin @(negedge clk_sys); n++; end while (!cpu_ack && n < 300);
            if (!cpu_ack) begin fail("cpu_ack_timeout"); cpu_req = 1'b0; return; end
            #1;
        end
        cpu_req = 1'b0;
    endtask

    task automatic dma_drive();
        int n;
        foreach (dma_list[i]) begin
            dma_we = dma_list[i].we;  dma_addr = dma_list[i].addr;
            dma_din = dma_list[i].din; dma_req = 1'b1;
            n = 0;
            do begin @(negedge clk_sys); n++; end while (!dma_ack && n < 300);
            if (!dma_ack) begin fail("dma_ack_timeout"); dma_req = 1'b0; return; end
            #1;
        end
        dma_req = 1'b0;
    endtask

    // Both ports start together and re-request right after each ack; model predicts service order.
    // First grant latency, counted from the request cycle to the ack cycle: 3 + busy length
    // (4 + busy when both end cycles are counted), or 2 + timeout when busy never rises.
    task automatic run_scenario(input int blen);
        int ci, di, lat;
        bit d, first;
        ci = 0; di = 0; first = 1'b1;
        busy_len = blen;
        while (ci < cpu_list.size() || di < dma_list.size()) begin
            if (ci < cpu_list.size() && di < dma_list.size()) d = RR ? !model_last : 1'b0;
            else d = (ci >= cpu_list.size());
            lat = first ? ((blen > 0) ? 3 + blen : 2 + BUSY_TO) : -1;
            push_exp(d, d ? dma_list[di] : cpu_list[ci], blen > 0, lat);
            if (d) di++; else ci++;
            first = 1'b0;
        end
        @(negedge clk_sys); #1;
        scen_start = cyc;
        fork
            cpu_drive();
            dma_drive();
        join
        repeat (3) @(negedge clk_sys);
    endtask

    function automatic acc_t rand_acc();
        acc_t r;
        r.we   = 1'($urandom);
        r.addr = ($urandom_range(0, 1) == 1) ? 23'($urandom_range(0, 15)) : 23'($urandom);
        r.din  = 8'($urandom);
        return r;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 50000 cycles");
        $fatal(1, "watchdog");
    end

    initial begin
        acc_t a;
        int   s0, n;
        reset = 1'b1; hold_busy = 1'b0; busy_len = 2; model_last = 1'b1;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_din = '0;
        dma_req = 0; dma_we = 0; dma_addr = '0; dma_din = '0;
        exp_dout[0] = 8'd0; exp_dout[1] = 8'd0;
        repeat (3) @(negedge clk_sys);
        check_zero("reset");
        #1 reset = 1'b0;

        // CPU write, busy 3 cycles
        cpu_list.delete(); dma_list.delete();
        a.we = 1'b1; a.addr = 23'h012345; a.din = 8'hA5;
        cpu_list.push_back(a);
        run_scenario(3);

        // CPU read returning 3C
        sd_mem[25'h0000010] = 8'h3C; ref_mem[25'h0000010] = 8'h3C;
        cpu_list.delete();
        a.we = 1'b0; a.addr = 23'h000010; a.din = 8'h00;
        cpu_list.push_back(a);
        run_scenario(2);

        // Four back-to-back requests from each port: exercises tie policy
        cpu_list.delete(); dma_list.delete();
        for (int i = 0; i < 4; i++) begin
            cpu_list.push_back(rand_acc());
            dma_list.push_back(rand_acc());
        end
        run_scenario(2);

        // DMA read at top address with a channel that never goes busy
        cpu_list.delete(); dma_list.delete();
        a.we = 1'b0; a.addr = 23'h7FFFFF; a.din = 8'h00;
        dma_list.push_back(a);
        run_scenario(0);

        // Reset while waiting for busy to fall: no ack, everything cleared
        @(negedge clk_sys); #1;
        busy_len = 6;
        sq.push_back('{we: 1'b0, addr: 25'h080ABCD, din: 8'h00});
        dma_we = 1'b0; dma_addr = 23'h00ABCD; dma_din = 8'h00; dma_req = 1'b1;
        repeat (3) @(negedge clk_sys);
        #1 reset = 1'b1; dma_req = 1'b0;
        @(negedge clk_sys);
        check_zero("rst_mid");
        #1 reset = 1'b0;
        model_last = 1'b1; exp_dout[0] = 8'd0; exp_dout[1] = 8'd0;
        repeat (12) @(negedge clk_sys);
        chk("rst_strobe_seen", 32'(sq.size()), 32'd0);
        cpu_list.delete(); dma_list.delete();
        a.we = 1'b0; a.addr = 23'h00ABCD; a.din = 8'h00;
        dma_list.push_back(a);
        run_scenario(2);

        // Channel busy while idle: request must wait for busy to drop
        @(negedge clk_sys); #1;
        hold_busy = 1'b1; s0 = strobe_cnt;
        cpu_we = 1'b1; cpu_addr = 23'h000222; cpu_din = 8'h77; cpu_req = 1'b1;
        repeat (5) @(negedge clk_sys);
        chk("hold_no_strobe", 32'(strobe_cnt), 32'(s0));
        a.we = 1'b1; a.addr = 23'h000222; a.din = 8'h77;
        push_exp(1'b0, a, 1'b1, -1);
        busy_len = 2;
        #1 hold_busy = 1'b0;
        n = 0;
        do begin @(negedge clk_sys); n++; end while (!cpu_ack && n < 300);
        if (!cpu_ack) fail("hold_ack_timeout");
        #1 cpu_req = 1'b0;
        repeat (3) @(negedge clk_sys);

        // Randomized mixes of single and contending traffic
        for (int t = 0; t < 25; t++) begin
            int nc, nd;
            cpu_list.delete(); dma_list.delete();
            nc = $urandom_range(0, 3);
            nd = $urandom_range(0, 3);
            if (nc + nd == 0) nc = 1;
            for (int i = 0; i < nc; i++) cpu_list.push_back(rand_acc());
            for (int i = 0; i < nd; i++) dma_list.push_back(rand_acc());
            run_scenario($urandom_range(1, 4));
        end

        repeat (5) @(negedge clk_sys);
        chk("strobes_drained", 32'(sq.size()), 32'd0);
        chk("acks_drained", 32'(aq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
